if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the MIPS core, directly upstream of the 32-word instruction ROM.
- Holds the program counter and drives the ROM byte address.
- Latches the returned instruction word into the IF/ID register together with its PC+4.
- Handles stall, branch/jump redirect with one-slot squash, and a delivered-instruction counter.

---
 rtl/if_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of the MIPS core. Owns the program counter, drives
//   the byte address of the 32-word instruction ROM and captures the returned
//   word into the IF/ID register together with its PC+4.
//
//   Ports
//     Clk           rising-edge clock
//     Reset         synchronous active-high reset
//     Stall         hold PC and IR (decode/hazard back-pressure)
//     Branch_Taken  redirect to Branch_Target (for the instruction in IR)
//     Branch_Target byte address of the taken branch
//     Jump          redirect for a J-type instruction in IR
//     Jump_Index    instr_index field of the jump in IR
//     Inst          instruction word from the ROM (combinational on Addr)
//     Addr          ROM byte address, always equal to the PC register
//     IR            IF/ID instruction register
//     IF_PC4        PC+4 of the instruction held in IR
//     IF_Valid      IR holds a real fetched instruction (not a bubble)
//     Fetch_Count   valid instructions delivered since reset (wraps)
//     Misalign      sticky flag, misaligned redirect target seen
//                   (only when FETCH_MISALIGN_EN is defined)
//
//   Optional feature macro: FETCH_MISALIGN_EN
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump,
  input  logic [25:0] Jump_Index,
  input  logic [31:0] Inst,
  output logic [31:0] Addr,
  output logic [31:0] IR,
  output logic [31:0] IF_PC4,
  output logic        IF_Valid,
  output logic [31:0] Fetch_Count
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        Misalign
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;
  logic [31:0] count_reg, count_next;

  // A redirect only counts when IR holds a real instruction; a bubble cannot
  // branch. Jump outranks Branch_Taken.
  logic        jump_take;
  logic        branch_take;
  logic [31:0] jump_target;
  logic [31:0] branch_target_aligned;
  logic [31:0] pc_plus4;

  assign jump_take             = Jump & valid_reg;
  assign branch_take           = Branch_Taken & valid_reg & ~jump_take;
  assign jump_target           = {pc4_reg[31:28], Jump_Index, 2'b00};
  assign branch_target_aligned = {Branch_Target[31:2], 2'b00};
  assign pc_plus4              = pc_reg + 32'd4;

`ifdef FETCH_MISALIGN_EN
  logic misalign_reg, misalign_next;

  // Jump targets are always word-aligned by construction, so only the
  // branch target can trip the flag.
  always_comb begin
    misalign_next = misalign_reg;
    if (branch_take && (Branch_Target[1:0] != 2'b00)) begin
      misalign_next = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
    end
  end

  assign Misalign = misalign_reg;
`else
  // Low target bits are dropped silently in this build.
  logic unused_target_low;
  assign unused_target_low = |Branch_Target[1:0];
`endif

  // Next-state and datapath selection. BOOT ignores Stall and redirects so the
  // first word at RESET_PC is always delivered.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    pc4_next   = pc4_reg;
    valid_next = valid_reg;
    count_next = count_reg;

    case (state_reg)
      ST_BOOT: begin
        ir_next    = Inst;
        pc4_next   = pc_plus4;
        valid_next = 1'b1;
        pc_next    = pc_plus4;
        count_next = count_reg + 32'd1;
        state_next = ST_RUN;
      end
      default: begin
        if (jump_take) begin
          pc_next    = jump_target;
          ir_next    = NOP_INST;
          valid_next = 1'b0;
          state_next = ST_SQUASH;
        end else if (branch_take) begin
          pc_next    = branch_target_aligned;
          ir_next    = NOP_INST;
          valid_next = 1'b0;
          state_next = ST_SQUASH;
        end else if (Stall) begin
          // everything holds, including the state
          state_next = state_reg;
        end else begin
          ir_next    = Inst;
          pc4_next   = pc_plus4;
          valid_next = 1'b1;
          pc_next    = pc_plus4;
          count_next = count_reg + 32'd1;
          state_next = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_BOOT;
      pc_reg    <= RESET_PC;
      ir_reg    <= NOP_INST;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      pc4_reg   <= pc4_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  assign Addr        = pc_reg;
  assign IR          = ir_reg;
  assign IF_PC4      = pc4_reg;
  assign IF_Valid    = valid_reg;
  assign Fetch_Count = count_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed test-plan sequence followed by a randomized phase. A behavioural
//   model of the fetch rules (PC, IR, PC+4, valid, count, pending-boot flag)
//   runs alongside the DUT and every cycle's outputs are compared to it.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [25:0] Jump_Index;
  logic [31:0] Inst;
  logic [31:0] Addr;
  logic [31:0] IR;
  logic [31:0] IF_PC4;
  logic        IF_Valid;
  logic [31:0] Fetch_Count;
`ifdef FETCH_MISALIGN_EN
  logic        Misalign;
`endif

  always #5 Clk = ~Clk;

  if_fetch_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .Branch_Taken (Branch_Taken),
    .Branch_Target(Branch_Target),
    .Jump         (Jump),
    .Jump_Index   (Jump_Index),
    .Inst         (Inst),
    .Addr         (Addr),
    .IR           (IR),
    .IF_PC4       (IF_PC4),
    .IF_Valid     (IF_Valid),
    .Fetch_Count  (Fetch_Count)
`ifdef FETCH_MISALIGN_EN
    ,
    .Misalign     (Misalign)
`endif
  );

  // 32-word ROM, combinational on the word index of Addr.
  logic [31:0] rom [32];
  assign Inst = rom[Addr[6:2]];

  // Reference model state.
  logic [31:0] m_pc, m_ir, m_pc4, m_cnt;
  logic        m_valid, m_boot, m_mis;

  int errors = 0;
  int checks = 0;
  int stepno = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the fetch rules, using the inputs currently applied.
  task automatic model_edge();
    if (Reset) begin
      m_pc = 32'h0; m_ir = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_cnt = 32'h0; m_boot = 1'b1; m_mis = 1'b0;
    end else if (m_boot) begin
      m_ir = rom[m_pc[6:2]]; m_pc = m_pc + 4; m_pc4 = m_pc;
      m_valid = 1'b1; m_cnt = m_cnt + 1; m_boot = 1'b0;
    end else if (m_valid && Jump) begin
      m_pc = {m_pc4[31:28], Jump_Index, 2'b00};
      m_ir = 32'h0; m_valid = 1'b0;
    end else if (m_valid && Branch_Taken) begin
      if (Branch_Target % 4 != 0) m_mis = 1'b1;
      m_pc = Branch_Target - (Branch_Target % 4);
      m_ir = 32'h0; m_valid = 1'b0;
    end else if (!Stall) begin
      m_ir = rom[m_pc[6:2]]; m_pc = m_pc + 4; m_pc4 = m_pc;
      m_valid = 1'b1; m_cnt = m_cnt + 1;
    end
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    stepno++;
    chk({tag, ".addr"},  Addr,            m_pc);
    chk({tag, ".ir"},    IR,              m_ir);
    chk({tag, ".pc4"},   IF_PC4,          m_pc4);
    chk({tag, ".valid"}, {31'b0, IF_Valid}, {31'b0, m_valid});
    chk({tag, ".count"}, Fetch_Count,     m_cnt);
`ifdef FETCH_MISALIGN_EN
    chk({tag, ".misalign"}, {31'b0, Misalign}, {31'b0, m_mis});
`endif
    $display("step %0d %s rst=%b stl=%b j=%b br=%b addr=%h ir=%h pc4=%h v=%b cnt=%0d",
             stepno, tag, Reset, Stall, Jump, Branch_Taken, Addr, IR, IF_PC4,
             IF_Valid, Fetch_Count);
  endtask

  task automatic idle();
    Reset = 1'b0; Stall = 1'b0; Jump = 1'b0; Branch_Taken = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    rom[0] = 32'h0800_0005;
    rom[5] = 32'h3401_1234;
    m_pc = 0; m_ir = 0; m_pc4 = 0; m_cnt = 0; m_valid = 0; m_boot = 1; m_mis = 0;
    idle();
    Branch_Target = 32'h0; Jump_Index = 26'h0;

    // Reset for two cycles, then boot.
    Reset = 1'b1;
    step("reset0");
    step("reset1");
    chk("reset_ir", IR, 32'h0);
    chk("reset_cnt", Fetch_Count, 32'h0);
    Reset = 1'b0;
    chk("boot_addr", Addr, 32'h0);
    step("boot");
    chk("boot_ir", IR, 32'h0800_0005);
    chk("boot_pc4", IF_PC4, 32'h4);
    chk("boot_addr4", Addr, 32'h4);
    chk("boot_cnt", Fetch_Count, 32'h1);

    // Jump to index 5.
    Jump = 1'b1; Jump_Index = 26'd5;
    step("jump");
    chk("jump_addr", Addr, 32'h14);
    chk("jump_valid", {31'b0, IF_Valid}, 32'h0);
    Jump = 1'b0;
    step("jump_fill");
    chk("jump_fill_ir", IR, 32'h3401_1234);
    chk("jump_fill_pc4", IF_PC4, 32'h18);
    step("seq");
    chk("seq_addr", Addr, 32'h1C);

    // Stall for three cycles at 0x1C.
    Stall = 1'b1;
    repeat (3) step("stall");
    chk("stall_addr", Addr, 32'h1C);
    chk("stall_cnt", Fetch_Count, 32'h3);
    Stall = 1'b0;
    step("stall_rel");
    chk("stall_rel_ir", IR, rom[7]);
    chk("stall_rel_addr", Addr, 32'h20);

    // Branch together with Stall: redirect wins.
    Branch_Taken = 1'b1; Branch_Target = 32'h14; Stall = 1'b1;
    step("br_stall");
    chk("br_stall_addr", Addr, 32'h14);
    chk("br_stall_cnt", Fetch_Count, 32'h4);
    idle();
    step("br_fill");

    // Jump and branch together: jump wins.
    Jump = 1'b1; Jump_Index = 26'd8; Branch_Taken = 1'b1; Branch_Target = 32'h40;
    step("jmp_br");
    chk("jmp_br_addr", Addr, 32'h20);
    Jump = 1'b0;
    step("sq_ignore");
    chk("sq_ignore_addr", Addr, 32'h24);
    idle();
    repeat (3) step("seq");
    chk("pre_rst_addr", Addr, 32'h30);

    // Reset mid-run.
    Reset = 1'b1;
    step("mid_reset");
    chk("mid_reset_addr", Addr, 32'h0);
    chk("mid_reset_cnt", Fetch_Count, 32'h0);
    Reset = 1'b0;
    step("boot2");

    // Misaligned branch target: low bits cleared.
    Branch_Taken = 1'b1; Branch_Target = 32'h16;
    step("misalign");
    chk("misalign_addr", Addr, 32'h14);
    idle();
    step("seq");

    // PC wrap from 0xFFFF_FFFC.
    Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFC;
    step("br_top");
    idle();
    step("wrap");
    chk("wrap_addr", Addr, 32'h0);
    chk("wrap_pc4", IF_PC4, 32'h0);

    // Randomized phase.
    for (int n = 0; n < 300; n++) begin
      Reset         = ($urandom_range(0, 39) == 0);
      Stall         = ($urandom_range(0, 3) == 0);
      Jump          = ($urandom_range(0, 7) == 0);
      Branch_Taken  = ($urandom_range(0, 5) == 0);
      Jump_Index    = 26'($urandom);
      Branch_Target = $urandom;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
